// File: rtl/responder_arbiter_if.sv
// Host/key-side bundle of the responder arbiter: raw keys and host pulses in,
// winner/timer status out.
interface responder_arbiter_if;
  logic [4:0] keys;
  logic       start;
  logic       clear;
  logic       ack;
  logic       armed;
  logic       winner_valid;
  logic [2:0] winner_id;
  logic [6:0] time_left;
  logic       timeout;

  modport master (
    output keys, start, clear, ack,
    input  armed, winner_valid, winner_id, time_left, timeout
  );

  modport slave (
    input  keys, start, clear, ack,
    output armed, winner_valid, winner_id, time_left, timeout
  );
endinterface

// File: rtl/responder_arbiter.sv
// First-press arbiter for five players: synchronises the key bus, latches the
// first rising edge after a round opens and runs a tick-based answer countdown.
module responder_arbiter #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int ANSWER_SECS = 20
) (
  input  logic               clk,
  input  logic               rst,
  responder_arbiter_if.slave bus
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0]      WINDOW    = 7'(ANSWER_SECS);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOCKED, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    s1_q, s2_q, prev_q;
  logic [4:0]    press;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    id_q, id_d;
  logic          vld_q, vld_d;
  logic [6:0]    tl_q, tl_d;
  logic          to_q, to_d;

  // Bit 4 is player 1, so the highest set bit names the lowest player number.
  function automatic logic [2:0] first_player(input logic [4:0] p);
    logic [2:0] r;
    r = 3'd0;
    if (p[4])      r = 3'd1;
    else if (p[3]) r = 3'd2;
    else if (p[2]) r = 3'd3;
    else if (p[1]) r = 3'd4;
    else if (p[0]) r = 3'd5;
    return r;
  endfunction

  assign press = s2_q & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      state_q <= S_IDLE;
      presc_q <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      tl_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      s1_q    <= bus.keys;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      presc_q <= presc_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      tl_q    <= tl_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    id_d    = id_q;
    vld_d   = vld_q;
    tl_d    = tl_q;
    to_d    = to_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      id_d    = '0;
      vld_d   = 1'b0;
      tl_d    = '0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (|press) begin
            state_d = S_LOCKED;
            id_d    = first_player(press);
            vld_d   = 1'b1;
            tl_d    = WINDOW;
            presc_d = '0;
          end
        end
        S_LOCKED: begin
          // ack outranks the final tick, leaving one tick on the display.
          if (bus.ack) begin
            state_d = S_DONE;
            to_d    = 1'b0;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (tl_q == 7'd1) begin
              state_d = S_DONE;
              tl_d    = '0;
              to_d    = 1'b1;
            end else begin
              tl_d = tl_q - 7'd1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.start) begin
            state_d = S_ARMED;
            id_d    = '0;
            vld_d   = 1'b0;
            tl_d    = '0;
            to_d    = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.armed        = (state_q == S_ARMED);
  assign bus.winner_valid = vld_q;
  assign bus.winner_id    = id_q;
  assign bus.time_left    = tl_q;
  assign bus.timeout      = to_q;

endmodule

// File: tb/tb_responder_arbiter.sv
// Bench for responder_arbiter: directed round scenarios plus random traffic,
// all checked every cycle against a timeline-based model of a round.
module tb_responder_arbiter;
  localparam int TD = 4;
  localparam int AS = 3;
  localparam int M_IDLE = 0, M_ARMED = 1, M_LOCKED = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  responder_arbiter_if bus();

  responder_arbiter #(.TICK_DIV(TD), .ANSWER_SECS(AS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a round is a timeline. Keys seen at edge n are judged two edges later;
  // the countdown is derived from cycles elapsed since the lock.
  int m_mode, m_id, m_vld, m_tl, m_to, m_el;
  logic [4:0] kd1, kd2, kd3;

  function automatic int lowest_player(input logic [4:0] e);
    for (int i = 4; i >= 0; i--) if (e[i]) return 5 - i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_id = 0; m_vld = 0; m_tl = 0; m_to = 0; m_el = 0;
    kd1 = '0; kd2 = '0; kd3 = '0;
  endtask

  initial begin
    logic [4:0] edges;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        edges = kd2 & ~kd3;
        kd3 = kd2; kd2 = kd1; kd1 = bus.keys;
        if (bus.clear) begin
          m_mode = M_IDLE; m_id = 0; m_vld = 0; m_tl = 0; m_to = 0;
        end else begin
          case (m_mode)
            M_IDLE:  if (bus.start) m_mode = M_ARMED;
            M_ARMED: if (edges != 0) begin
              m_mode = M_LOCKED; m_id = lowest_player(edges); m_vld = 1;
              m_el = 0; m_tl = AS;
            end
            M_LOCKED: begin
              m_el++;
              if (bus.ack) m_mode = M_DONE;
              else if (m_el >= AS * TD) begin
                m_mode = M_DONE; m_tl = 0; m_to = 1;
              end else m_tl = AS - m_el / TD;
            end
            M_DONE: if (bus.start) begin
              m_mode = M_ARMED; m_id = 0; m_vld = 0; m_tl = 0; m_to = 0;
            end
            default: m_mode = M_IDLE;
          endcase
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("armed",        int'(bus.armed),        int'(m_mode == M_ARMED));
        check("winner_valid", int'(bus.winner_valid), m_vld);
        check("winner_id",    int'(bus.winner_id),    m_id);
        check("time_left",    int'(bus.time_left),    m_tl);
        check("timeout",      int'(bus.timeout),      m_to);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1; tick(1); bus.ack = 1'b0;
  endtask

  initial begin
    bus.keys = '0; bus.start = 1'b0; bus.clear = 1'b0; bus.ack = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_armed", int'(bus.armed), 0);
    check("rst_valid", int'(bus.winner_valid), 0);

    // Idle press is ignored.
    bus.keys = 5'b00100; tick(5);
    check("idle_valid", int'(bus.winner_valid), 0);
    check("idle_id",    int'(bus.winner_id), 0);
    check("idle_armed", int'(bus.armed), 0);
    bus.keys = '0; tick(3);

    // Single winner, three-edge latency, later press ignored.
    pulse_start(); tick(1);
    bus.keys = 5'b00010; tick(2);
    check("lat_early_valid", int'(bus.winner_valid), 0);
    tick(1);
    check("lat_id",    int'(bus.winner_id), 4);
    check("lat_valid", int'(bus.winner_valid), 1);
    bus.keys = 5'b10000; tick(4);
    check("late_press_id", int'(bus.winner_id), 4);
    bus.keys = '0; pulse_ack(); tick(2);

    // Simultaneous press and key held across start.
    pulse_start();
    bus.keys = 5'b01011; tick(1); bus.keys = '0; tick(2);
    check("simul_id", int'(bus.winner_id), 2);
    pulse_ack();
    bus.keys = 5'b00001; tick(3);
    pulse_start(); tick(4);
    check("held_armed", int'(bus.armed), 1);
    check("held_valid", int'(bus.winner_valid), 0);
    bus.keys = '0; tick(3);
    bus.keys = 5'b00001; tick(3);
    check("repress_id", int'(bus.winner_id), 5);
    bus.keys = '0; pulse_ack(); tick(2);

    // Timeout countdown.
    pulse_start();
    bus.keys = 5'b00100; tick(3);
    check("to_tl3", int'(bus.time_left), 3);
    bus.keys = '0; tick(4);
    check("to_tl2", int'(bus.time_left), 2);
    tick(4);
    check("to_tl1", int'(bus.time_left), 1);
    tick(4);
    check("to_tl0",    int'(bus.time_left), 0);
    check("to_flag",   int'(bus.timeout), 1);
    check("to_valid",  int'(bus.winner_valid), 1);
    pulse_ack(); tick(1);
    check("to_hold", int'(bus.timeout), 1);

    // Ack on the final tick.
    pulse_start();
    bus.keys = 5'b10000; tick(3);
    check("race_id", int'(bus.winner_id), 1);
    bus.keys = '0; tick(11);
    pulse_ack();
    check("race_tl", int'(bus.time_left), 1);
    check("race_to", int'(bus.timeout), 0);
    tick(3);
    check("race_hold_tl", int'(bus.time_left), 1);
    pulse_start();
    check("rearm_id",    int'(bus.winner_id), 0);
    check("rearm_armed", int'(bus.armed), 1);

    // Clear beats start; async reset mid-cycle.
    bus.keys = 5'b01000; tick(3);
    check("pre_clear_valid", int'(bus.winner_valid), 1);
    bus.keys = '0;
    bus.clear = 1'b1; bus.start = 1'b1; tick(1);
    bus.clear = 1'b0; bus.start = 1'b0;
    check("clr_armed", int'(bus.armed), 0);
    check("clr_valid", int'(bus.winner_valid), 0);
    check("clr_id",    int'(bus.winner_id), 0);
    check("clr_tl",    int'(bus.time_left), 0);
    pulse_start();
    bus.keys = 5'b00001; tick(3); bus.keys = '0;
    check("pre_rst_id", int'(bus.winner_id), 5);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", int'(bus.winner_valid), 0);
    check("arst_id",    int'(bus.winner_id), 0);
    check("arst_tl",    int'(bus.time_left), 0);
    tick(1); rst = 1'b0; tick(2);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      int b;
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, 4);
        bus.keys[b] = ~bus.keys[b];
      end
      bus.start = ($urandom_range(0, 11) == 0);
      bus.clear = ($urandom_range(0, 79) == 0);
      bus.ack   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        tick(1); rst = 1'b0;
      end else tick(1);
    end
    bus.keys = '0; bus.start = 1'b0; bus.clear = 1'b0; bus.ack = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
